// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encodings, the word-alignment
// mask and a misalignment helper.
package mem_stage_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_ACCESS  = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b00;

    // True when the low address bits do not select a word boundary.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the memory stage's execute-side, data-memory and writeback signals.
//   master : environment view (execute unit, data memory, register file)
//   slave  : memory-stage view
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ex_result;
    logic              ex_overflow;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_memwr;
    logic              ex_memrd;
    logic              ex_regwr;
    logic [REG_AW-1:0] ex_rw;
    logic              flush;
    logic              stall;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    logic              wb_valid;
    logic              wb_regwr;
    logic [REG_AW-1:0] wb_rw;
    logic [DATA_W-1:0] wb_data;
    logic              exc_ovf;
    logic              exc_align;

    modport master (
        output in_valid, ex_result, ex_overflow, ex_store_data, ex_memwr,
               ex_memrd, ex_regwr, ex_rw, flush, dmem_ack, dmem_rdata,
        input  in_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_regwr, wb_rw, wb_data, exc_ovf, exc_align
    );

    modport slave (
        input  in_valid, ex_result, ex_overflow, ex_store_data, ex_memwr,
               ex_memrd, ex_regwr, ex_rw, flush, dmem_ack, dmem_rdata,
        output in_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_regwr, wb_rw, wb_data, exc_ovf, exc_align
    );
endinterface

// File: rtl/mem_stage_dmem_if.sv
// Data-memory request side of the memory stage.
// Holds req/we/addr/wdata stable from start until ack, keeps the writeback
// controls of the outstanding access, and presents ack-qualified read data.
//   start/start_*  : launch an access with these attributes (next cycle req=1)
//   ack/rdata      : memory handshake inputs
//   req/we/addr/wdata : registered memory request
//   regwr_q/rw_q   : latched writeback controls of the outstanding access
//   done_c/rdata_c : access completes this cycle / its read data
module mem_stage_dmem_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              start_regwr,
    input  logic [REG_AW-1:0] start_rw,
    input  logic              ack,
    input  logic [DATA_W-1:0] rdata,
    output logic              req,
    output logic              we,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              regwr_q,
    output logic [REG_AW-1:0] rw_q,
    output logic              done_c,
    output logic [DATA_W-1:0] rdata_c
);

    // An ack only counts while a request is outstanding.
    assign done_c  = req & ack;
    assign rdata_c = done_c ? rdata : '0;

    // Request registers: loaded on start, released on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req     <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            regwr_q <= 1'b0;
            rw_q    <= '0;
        end else if (start) begin
            req     <= 1'b1;
            we      <= start_we;
            addr    <= {start_addr[DATA_W-1:2], ALIGN_MASK};
            wdata   <= start_wdata;
            regwr_q <= start_regwr;
            rw_q    <= start_rw;
        end else if (done_c) begin
            req     <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: accepts execute results, performs loads/stores over
// a req/ack data-memory handshake, stalls upstream while an access is
// outstanding, and emits a one-cycle registered writeback bundle with
// overflow / misalignment exception flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : execute inputs, in_ready/stall, dmem handshake, writeback
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_stage_if.slave   bus
);

    logic [0:0]        state, state_d;
    logic              accept, is_mem, start, done_c;
    logic              acc_regwr;
    logic [REG_AW-1:0] acc_rw;
    logic [DATA_W-1:0] acc_rdata;

    logic              wb_valid, wb_valid_d;
    logic              wb_regwr, wb_regwr_d;
    logic [REG_AW-1:0] wb_rw, wb_rw_d;
    logic [DATA_W-1:0] wb_data, wb_data_d;
    logic              exc_ovf, exc_ovf_d;
    logic              exc_align, exc_align_d;

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.stall    = (state == ST_ACCESS);

    assign accept = bus.in_valid & (state == ST_IDLE) & ~bus.flush;
    assign is_mem = bus.ex_memwr | bus.ex_memrd;

    // A store wins when both memwr and memrd are set.
    mem_stage_dmem_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dmem (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (bus.ex_memwr),
        .start_addr  (bus.ex_result),
        .start_wdata (bus.ex_store_data),
        .start_regwr (bus.ex_regwr),
        .start_rw    (bus.ex_rw),
        .ack         (bus.dmem_ack),
        .rdata       (bus.dmem_rdata),
        .req         (bus.dmem_req),
        .we          (bus.dmem_we),
        .addr        (bus.dmem_addr),
        .wdata       (bus.dmem_wdata),
        .regwr_q     (acc_regwr),
        .rw_q        (acc_rw),
        .done_c      (done_c),
        .rdata_c     (acc_rdata)
    );

    // Next state, access launch and writeback bundle.
    always_comb begin
        state_d     = state;
        start       = 1'b0;
        wb_valid_d  = 1'b0;
        wb_regwr_d  = 1'b0;
        wb_rw_d     = wb_rw;
        wb_data_d   = wb_data;
        exc_ovf_d   = 1'b0;
        exc_align_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.ex_overflow) begin
                        wb_valid_d = 1'b1;
                        exc_ovf_d  = 1'b1;
                    end else if (is_mem && misaligned(bus.ex_result[1:0])) begin
                        wb_valid_d  = 1'b1;
                        exc_align_d = 1'b1;
                    end else if (is_mem) begin
                        start   = 1'b1;
                        state_d = ST_ACCESS;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_regwr_d = bus.ex_regwr;
                        wb_rw_d    = bus.ex_rw;
                        wb_data_d  = bus.ex_result;
                    end
                end
            end
            ST_ACCESS: begin
                if (done_c) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_regwr_d = acc_regwr & ~bus.dmem_we;
                    wb_rw_d    = acc_rw;
                    if (!bus.dmem_we) begin
                        wb_data_d = acc_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wb_valid  <= 1'b0;
            wb_regwr  <= 1'b0;
            wb_rw     <= '0;
            wb_data   <= '0;
            exc_ovf   <= 1'b0;
            exc_align <= 1'b0;
        end else begin
            state     <= state_d;
            wb_valid  <= wb_valid_d;
            wb_regwr  <= wb_regwr_d;
            wb_rw     <= wb_rw_d;
            wb_data   <= wb_data_d;
            exc_ovf   <= exc_ovf_d;
            exc_align <= exc_align_d;
        end
    end

    assign bus.wb_valid  = wb_valid;
    assign bus.wb_regwr  = wb_regwr;
    assign bus.wb_rw     = wb_rw;
    assign bus.wb_data   = wb_data;
    assign bus.exc_ovf   = exc_ovf;
    assign bus.exc_align = exc_align;

endmodule
